// File: rtl/video_timing_gen.sv
// Raster timing generator: HPOS/VPOS counters, pipelined blank/sync/DE decode,
// blanked RGB, run-time sync centring and line/frame strobes on a pixel enable.
module video_timing_gen #(
    parameter int RGB_W    = 12,
    parameter int CNT_W    = 9,
    parameter int H_ACTIVE = 288,
    parameter int H_FP     = 20,
    parameter int H_SYNC   = 32,
    parameter int H_BP     = 44,
    parameter int V_ACTIVE = 224,
    parameter int V_FP     = 11,
    parameter int V_SYNC   = 7,
    parameter int V_BP     = 21,
    parameter int SYNC_POL = 0
) (
    input  logic             MCLK,
    input  logic             RESET_N,
    input  logic             PCE,
    input  logic [3:0]       H_ADJ,
    input  logic [2:0]       V_ADJ,
    input  logic [RGB_W-1:0] iRGB,
    output logic [CNT_W-1:0] HPOS,
    output logic [CNT_W-1:0] VPOS,
    output logic [RGB_W-1:0] oRGB,
    output logic             HBLK,
    output logic             VBLK,
    output logic             HSYN,
    output logic             VSYN,
    output logic             DE,
    output logic             LINE_ST,
    output logic             FRAME_ST
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    localparam logic signed [CNT_W:0] HS_BASE = (CNT_W+1)'(H_ACTIVE + H_FP);
    localparam logic signed [CNT_W:0] HS_LEN  = (CNT_W+1)'(H_SYNC);
    localparam logic signed [CNT_W:0] VS_BASE = (CNT_W+1)'(V_ACTIVE + V_FP);
    localparam logic signed [CNT_W:0] VS_LEN  = (CNT_W+1)'(V_SYNC);

    // Sync level while the pulse is asserted
    localparam logic S_ON = (SYNC_POL != 0);

    logic [CNT_W-1:0]        hcnt;
    logic [CNT_W-1:0]        vcnt;
    logic [3:0]              ha;
    logic [2:0]              va;
    logic                    h_wrap;
    logic                    v_wrap;
    logic signed [CNT_W:0]   h_pos;
    logic signed [CNT_W:0]   v_pos;
    logic signed [CNT_W:0]   hs_beg;
    logic signed [CNT_W:0]   hs_end;
    logic signed [CNT_W:0]   vs_beg;
    logic signed [CNT_W:0]   vs_end;
    logic                    hs_on;
    logic                    vs_on;
    logic                    hblk_n;
    logic                    vblk_n;
    logic                    de_n;

    assign h_wrap = (hcnt == H_LAST);
    assign v_wrap = (vcnt == V_LAST);

    // Sync windows from the frame-latched adjusts, sign-extended
    assign h_pos  = $signed({1'b0, hcnt});
    assign v_pos  = $signed({1'b0, vcnt});
    assign hs_beg = HS_BASE + $signed({{(CNT_W-3){ha[3]}}, ha});
    assign hs_end = hs_beg + HS_LEN;
    assign vs_beg = VS_BASE + $signed({{(CNT_W-2){va[2]}}, va});
    assign vs_end = vs_beg + VS_LEN;
    assign hs_on  = (h_pos >= hs_beg) && (h_pos < hs_end);
    assign vs_on  = (v_pos >= vs_beg) && (v_pos < vs_end);

    assign hblk_n = (hcnt >= H_ACT);
    assign vblk_n = (vcnt >= V_ACT);
    assign de_n   = ~(hblk_n | vblk_n);

    assign HPOS = hcnt;
    assign VPOS = vcnt;

    // Raster counters, advancing once per pixel enable
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (PCE) begin
            hcnt <= h_wrap ? '0 : hcnt + ONE;
            if (h_wrap)
                vcnt <= v_wrap ? '0 : vcnt + ONE;
        end
    end

    // Decode of the pre-increment position, one pixel behind HPOS/VPOS
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            HBLK <= 1'b1;
            VBLK <= 1'b1;
            DE   <= 1'b0;
            HSYN <= ~S_ON;
            VSYN <= ~S_ON;
            oRGB <= '0;
        end else if (PCE) begin
            HBLK <= hblk_n;
            VBLK <= vblk_n;
            DE   <= de_n;
            HSYN <= hs_on ? S_ON : ~S_ON;
            VSYN <= vs_on ? S_ON : ~S_ON;
            oRGB <= de_n ? iRGB : '0;
        end
    end

    // Wrap strobes, and adjust capture only at frame boundary
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            LINE_ST  <= 1'b0;
            FRAME_ST <= 1'b0;
            ha       <= '0;
            va       <= '0;
        end else begin
            LINE_ST  <= PCE & h_wrap;
            FRAME_ST <= PCE & h_wrap & v_wrap;
            if (PCE && h_wrap && v_wrap) begin
                ha <= H_ADJ;
                va <= V_ADJ;
            end
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a shrunk active-low build plus a default-size
// active-high build, both compared every MCLK against a raster position model.
module tb_video_timing_gen;

    typedef struct {
        int hact, hfp, hsw, hbp;
        int vact, vfp, vsw, vbp;
        int pol;
    } cfg_t;

    typedef struct {
        bit hblk, vblk, hsyn, vsyn, de;
    } dec_t;

    logic        MCLK = 1'b0;
    logic        RESET_N;
    logic        PCE;
    logic [3:0]  H_ADJ;
    logic [2:0]  V_ADJ;
    logic [11:0] iRGB;

    logic [8:0]  a_hpos, a_vpos, b_hpos, b_vpos;
    logic [11:0] a_rgb, b_rgb;
    logic a_hblk, a_vblk, a_hsyn, a_vsyn, a_de, a_ls, a_fs;
    logic b_hblk, b_vblk, b_hsyn, b_vsyn, b_de, b_ls, b_fs;

    int total = 0;
    int bad   = 0;

    cfg_t        cfg [2];
    int          n;
    int          mha [2];
    int          mva [2];
    dec_t        e [2];
    logic [11:0] erg [2];
    bit          eline [2];
    bit          efrm [2];

    int          hadj, vadj;

    always #5 MCLK = ~MCLK;

    video_timing_gen #(
        .RGB_W(12), .CNT_W(9),
        .H_ACTIVE(16), .H_FP(9), .H_SYNC(4), .H_BP(9),
        .V_ACTIVE(10), .V_FP(5), .V_SYNC(3), .V_BP(5),
        .SYNC_POL(0)
    ) dut (
        .MCLK(MCLK), .RESET_N(RESET_N), .PCE(PCE),
        .H_ADJ(H_ADJ), .V_ADJ(V_ADJ), .iRGB(iRGB),
        .HPOS(a_hpos), .VPOS(a_vpos), .oRGB(a_rgb),
        .HBLK(a_hblk), .VBLK(a_vblk), .HSYN(a_hsyn), .VSYN(a_vsyn),
        .DE(a_de), .LINE_ST(a_ls), .FRAME_ST(a_fs)
    );

    video_timing_gen #(
        .SYNC_POL(1)
    ) dut_def (
        .MCLK(MCLK), .RESET_N(RESET_N), .PCE(PCE),
        .H_ADJ(H_ADJ), .V_ADJ(V_ADJ), .iRGB(iRGB),
        .HPOS(b_hpos), .VPOS(b_vpos), .oRGB(b_rgb),
        .HBLK(b_hblk), .VBLK(b_vblk), .HSYN(b_hsyn), .VSYN(b_vsyn),
        .DE(b_de), .LINE_ST(b_ls), .FRAME_ST(b_fs)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int htot(input cfg_t c);
        return c.hact + c.hfp + c.hsw + c.hbp;
    endfunction

    function automatic int vtot(input cfg_t c);
        return c.vact + c.vfp + c.vsw + c.vbp;
    endfunction

    // Expected registered outputs for raster position p (pixels since reset)
    function automatic dec_t decode(input cfg_t c, input int p,
                                    input int ha, input int va);
        dec_t d;
        int h, v, hs0, vs0;
        bit hs, vs;
        h   = p % htot(c);
        v   = (p / htot(c)) % vtot(c);
        hs0 = c.hact + c.hfp + ha;
        vs0 = c.vact + c.vfp + va;
        hs  = (h >= hs0) && (h < hs0 + c.hsw);
        vs  = (v >= vs0) && (v < vs0 + c.vsw);
        d.hblk = (h >= c.hact);
        d.vblk = (v >= c.vact);
        d.de   = !(d.hblk || d.vblk);
        d.hsyn = (c.pol != 0) ? hs : !hs;
        d.vsyn = (c.pol != 0) ? vs : !vs;
        return d;
    endfunction

    task automatic model_reset();
        n = 0;
        for (int i = 0; i < 2; i++) begin
            mha[i]    = 0;
            mva[i]    = 0;
            e[i].hblk = 1;
            e[i].vblk = 1;
            e[i].de   = 0;
            e[i].hsyn = (cfg[i].pol == 0);
            e[i].vsyn = (cfg[i].pol == 0);
            erg[i]    = '0;
            eline[i]  = 0;
            efrm[i]   = 0;
        end
    endtask

    // Advance the model across one MCLK edge with the given inputs
    task automatic model_edge(input bit p, input int ha_in, input int va_in,
                              input logic [11:0] rgb);
        int ht, ft;
        for (int i = 0; i < 2; i++) begin
            ht = htot(cfg[i]);
            ft = ht * vtot(cfg[i]);
            if (p) begin
                e[i]     = decode(cfg[i], n, mha[i], mva[i]);
                erg[i]   = e[i].de ? rgb : 12'h000;
                eline[i] = ((n % ht) == ht - 1);
                efrm[i]  = ((n % ft) == ft - 1);
                if (efrm[i]) begin
                    mha[i] = ha_in;
                    mva[i] = va_in;
                end
            end else begin
                eline[i] = 0;
                efrm[i]  = 0;
            end
        end
        if (p)
            n++;
    endtask

    task automatic cmp_dut(input string nm, input int i,
                           input logic [8:0] hp, input logic [8:0] vp,
                           input logic hb, input logic vb,
                           input logic hs, input logic vs,
                           input logic de, input logic ls, input logic fs,
                           input logic [11:0] rgb);
        int ht;
        ht = htot(cfg[i]);
        chk({nm, ".hpos"},  32'(hp),  32'(n % ht));
        chk({nm, ".vpos"},  32'(vp),  32'((n / ht) % vtot(cfg[i])));
        chk({nm, ".hblk"},  32'(hb),  32'(e[i].hblk));
        chk({nm, ".vblk"},  32'(vb),  32'(e[i].vblk));
        chk({nm, ".hsyn"},  32'(hs),  32'(e[i].hsyn));
        chk({nm, ".vsyn"},  32'(vs),  32'(e[i].vsyn));
        chk({nm, ".de"},    32'(de),  32'(e[i].de));
        chk({nm, ".line"},  32'(ls),  32'(eline[i]));
        chk({nm, ".frame"}, 32'(fs),  32'(efrm[i]));
        chk({nm, ".rgb"},   32'(rgb), 32'(erg[i]));
    endtask

    task automatic check_all();
        cmp_dut("small", 0, a_hpos, a_vpos, a_hblk, a_vblk, a_hsyn, a_vsyn,
                a_de, a_ls, a_fs, a_rgb);
        cmp_dut("dflt", 1, b_hpos, b_vpos, b_hblk, b_vblk, b_hsyn, b_vsyn,
                b_de, b_ls, b_fs, b_rgb);
    endtask

    // Called at a falling edge: drive, predict the rising edge, check after it
    task automatic tick(input bit p, input logic [11:0] rgb);
        PCE   = p;
        iRGB  = rgb;
        H_ADJ = 4'(hadj);
        V_ADJ = 3'(vadj);
        model_edge(p, hadj, vadj, rgb);
        @(negedge MCLK);
        check_all();
    endtask

    task automatic run_random(input int cycles, input int pce_div,
                              input bit vary_adj);
        for (int k = 0; k < cycles; k++) begin
            if (vary_adj && $urandom_range(0, 149) == 0) begin
                hadj = $urandom_range(0, 15) - 8;
                vadj = $urandom_range(0, 7) - 4;
            end
            tick($urandom_range(0, pce_div - 1) == 0, 12'($urandom));
        end
    endtask

    initial begin
        cfg[0] = '{hact: 16, hfp: 9, hsw: 4, hbp: 9,
                   vact: 10, vfp: 5, vsw: 3, vbp: 5, pol: 0};
        cfg[1] = '{hact: 288, hfp: 20, hsw: 32, hbp: 44,
                   vact: 224, vfp: 11, vsw: 7, vbp: 21, pol: 1};
        hadj    = 0;
        vadj    = 0;
        RESET_N = 1'b0;
        PCE     = 1'b0;
        H_ADJ   = '0;
        V_ADJ   = '0;
        iRGB    = '0;
        model_reset();

        repeat (2) @(negedge MCLK);
        check_all();
        RESET_N = 1'b1;

        // Sparse random pixel enables, adjusts wandering mid-frame
        run_random(8000, 3, 1'b1);

        // Enable held low: everything frozen, adjust inputs ignored
        for (int k = 0; k < 50; k++) begin
            hadj = $urandom_range(0, 15) - 8;
            vadj = $urandom_range(0, 7) - 4;
            tick(1'b0, 12'($urandom));
        end

        // Extreme adjusts, full-rate enable, each for two small frames
        hadj = -8;
        vadj = -4;
        for (int k = 0; k < 1748; k++)
            tick(1'b1, 12'hFFF);
        hadj = 7;
        vadj = 3;
        for (int k = 0; k < 1748; k++)
            tick(1'b1, 12'($urandom));

        run_random(600, 1, 1'b1);

        // Asynchronous reset dropped between clock edges
        PCE = 1'b1;
        #2 RESET_N = 1'b0;
        #1;
        model_reset();
        check_all();
        for (int k = 0; k < 3; k++) begin
            @(negedge MCLK);
            check_all();
        end
        RESET_N = 1'b1;
        hadj = 2;
        vadj = -1;
        tick(1'b1, 12'h5A5);
        chk("hpos_after_reset", 32'(a_hpos), 32'd1);

        // Enable every eighth clock, then mixed
        run_random(1500, 8, 1'b1);
        run_random(1500, 2, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
